// File: rtl/serial_shifter_if.sv
// ============================================================================
//  Module      : serial_shifter_if
//  Description : Request/response bundle between the EX-stage issue logic
//                (master) and the multi-cycle serial shifter (slave).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface serial_shifter_if #(
  parameter int WIDTH = 32
) ();

  // Request side: sampled by the shifter only on the accepting edge
  logic             start;
  logic [1:0]       op;
  logic [31:0]      amt;
  logic [WIDTH-1:0] din;

  // Response side: all driven from registers inside the shifter
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] dout;

  modport master (
    output start,
    output op,
    output amt,
    output din,
    input  busy,
    input  done,
    input  dout
  );

  modport slave (
    input  start,
    input  op,
    input  amt,
    input  din,
    output busy,
    output done,
    output dout
  );

endinterface : serial_shifter_if

`default_nettype wire

// File: rtl/serial_shifter.sv
// ============================================================================
//  Module      : serial_shifter
//  Description : Multi-cycle SLL/SRL/SRA unit, one bit position per clock.
//                start/busy/done handshake lets the hazard unit stall the
//                pipeline while a shift is in flight.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module serial_shifter #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  serial_shifter_if.slave  bus
);

  // Shift operation encodings; 2'b11 falls through to SLL
  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] work_q;
  logic [WIDTH-1:0] work_d;
  logic [WIDTH-1:0] dout_q;
  logic [SHW-1:0]   count_q;
  logic [SHW-1:0]   count_d;
  logic [1:0]       op_q;
  logic             busy_q;
  logic             done_q;
  logic             accept;

  // Only the low SHW bits of the amount word carry meaning; the rest are
  // deliberately dropped (rs values may hold arbitrary upper bits).
  logic unused_amt_hi;
  assign unused_amt_hi = ^bus.amt[31:SHW];

  // A new request is taken from IDLE or straight out of DONE (back-to-back);
  // start during SHIFT is simply not looked at.
  assign accept = bus.start && (state_q != ST_SHIFT);

  // One-bit step of the working value according to the latched op
  always_comb begin
    work_d = work_q;
    unique case (op_q)
      OP_SRL:  work_d = {1'b0, work_q[WIDTH-1:1]};
      OP_SRA:  work_d = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
      OP_SLL:  work_d = {work_q[WIDTH-2:0], 1'b0};
      default: work_d = {work_q[WIDTH-2:0], 1'b0};
    endcase
  end

  // Remaining shift count after this step
  assign count_d = count_q - SHW'(1);

  // Control FSM plus datapath registers; busy/done/dout are all registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      work_q  <= '0;
      dout_q  <= '0;
      count_q <= '0;
      op_q    <= OP_SLL;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      // done is a single-cycle pulse unless re-raised below
      done_q <= 1'b0;

      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            work_q  <= bus.din;
            count_q <= bus.amt[SHW-1:0];
            op_q    <= bus.op;
            busy_q  <= 1'b1;
            state_q <= ST_SHIFT;
          end else begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end

        ST_SHIFT: begin
          if (count_q == '0) begin
            // Result is published only here, never mid-shift
            dout_q  <= work_q;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            work_q  <= work_d;
            count_q <= count_d;
          end
        end

        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.dout = dout_q;

endmodule : serial_shifter

`default_nettype wire

// File: tb/tb_serial_shifter.sv
// ============================================================================
//  Module      : tb_serial_shifter
//  Description : Directed-vector bench for serial_shifter.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_serial_shifter;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_miss;

  serial_shifter_if #(.WIDTH(32)) bus ();

  serial_shifter #(.WIDTH(32), .SHW(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for every check in the bench
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for done; returns number of negedges waited and whether
  // busy stayed high on every sample before done
  task automatic wait_done(output int lat, output bit busy_ok);
    lat     = 0;
    busy_ok = 1'b1;
    while (!bus.done && lat < 40) begin
      if (!bus.busy) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
  endtask

  // Issue one request with a single-cycle start pulse, scramble the inputs
  // right after acceptance, then check latency, busy, done and dout.
  task automatic run_op(input string tag, input logic [1:0] op,
                        input logic [31:0] amt, input logic [31:0] din,
                        input logic [31:0] exp, input int exp_lat);
    int lat;
    bit busy_ok;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.amt   = amt;
    bus.din   = din;
    @(negedge clk);
    bus.start = 1'b0;
    bus.op    = ~op;
    bus.amt   = 32'h0000_001F;
    bus.din   = ~din;
    wait_done(lat, busy_ok);
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " busy held"}, {31'd0, busy_ok}, 32'd1);
    check({tag, " dout"}, bus.dout, exp);
    check({tag, " busy at done"}, {31'd0, bus.busy}, 32'd0);
    @(negedge clk);
    check({tag, " done width"}, {31'd0, bus.done}, 32'd0);
    check({tag, " dout hold"}, bus.dout, exp);
  endtask

  initial begin
    int  lat;
    bit  busy_ok;
    bit  spurious;
    n_vec     = 0;
    n_miss    = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.amt   = '0;
    bus.din   = '0;
    repeat (3) @(negedge clk);
    check("reset busy", {31'd0, bus.busy}, 32'd0);
    check("reset done", {31'd0, bus.done}, 32'd0);
    check("reset dout", bus.dout, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("sll31",  2'b00, 32'd31,          32'h0000_0001, 32'h8000_0000, 32);
    run_op("sra4",   2'b10, 32'd4,           32'h8000_0000, 32'hF800_0000, 5);
    run_op("srl4",   2'b01, 32'd4,           32'h8000_0000, 32'h0800_0000, 5);
    run_op("srl25",  2'b01, 32'h0000_0025,   32'hFFFF_FFFF, 32'h07FF_FFFF, 6);
    run_op("amt0",   2'b10, 32'hFFFF_FFE0,   32'hA5A5_5A5A, 32'hA5A5_5A5A, 1);
    run_op("op3sll", 2'b11, 32'd4,           32'h0000_0003, 32'h0000_0030, 5);
    run_op("sra_pos",2'b10, 32'd2,           32'h4000_0000, 32'h1000_0000, 3);

    // Back-to-back: start held high, din changed mid-shift
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 2'b00;
    bus.amt   = 32'd3;
    bus.din   = 32'h0000_00F0;
    @(negedge clk);
    bus.din   = 32'h0000_0001;
    wait_done(lat, busy_ok);
    check("b2b first latency", 32'(lat), 32'd4);
    check("b2b first dout", bus.dout, 32'h0000_0780);
    check("b2b first busy", {31'd0, bus.busy}, 32'd0);
    @(negedge clk);
    check("b2b rebusy", {31'd0, bus.busy}, 32'd1);
    check("b2b done low", {31'd0, bus.done}, 32'd0);
    bus.start = 1'b0;
    wait_done(lat, busy_ok);
    check("b2b second latency", 32'(lat), 32'd4);
    check("b2b second dout", bus.dout, 32'h0000_0008);

    // Reset in the middle of an amt=10 shift
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 2'b00;
    bus.amt   = 32'd10;
    bus.din   = 32'h0000_0001;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    check("pre-reset busy", {31'd0, bus.busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid reset busy", {31'd0, bus.busy}, 32'd0);
    check("mid reset done", {31'd0, bus.done}, 32'd0);
    check("mid reset dout", bus.dout, 32'h0);
    @(negedge clk);
    rst_n    = 1'b1;
    spurious = 1'b0;
    repeat (16) begin
      @(negedge clk);
      if (bus.done || bus.busy) spurious = 1'b1;
    end
    check("no done after reset", {31'd0, spurious}, 32'd0);

    run_op("post_reset", 2'b01, 32'd8, 32'h1234_5678, 32'h0012_3456, 9);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  // Hard stop in case something hangs outside the bounded waits
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_serial_shifter

`default_nettype wire
